mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 31:1 x 2-bit channel mux. On start it walks sel

---
 rtl/mux_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer that scans the enabled channels of a 31:1 x DW-bit
// channel mux in ascending order.
// On start it captures the channel mask, drives sel_o to each enabled channel,
// waits one settle cycle, samples the mux output and presents each
// (channel, data) pair on a valid/ready stream. done pulses once, after the
// last sample has been accepted.
// When idle, sel_o parks at all-ones; the mux drives 0 on that select.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle scan request; ignored while busy
//   abort           synchronous cancel of an active scan (no done pulse)
//   ch_mask         channel enable mask, captured when a scan starts
//   sel_o           mux select
//   mux_out_i       mux output; combinational from sel_o
//   sample_data     captured mux data for channel sample_ch
//   sample_ch       channel of sample_data
//   sample_valid    stream valid; the pair is accepted when sample_ready is also high
//   sample_ready    stream ready
//   busy            high whenever a scan is in progress
//   done            one-cycle pulse after the final handshake of a scan
module mux_scan_ctrl #(
  parameter int unsigned NUM_CH = 31,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned DW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DW-1:0]     mux_out_i,
  output logic [DW-1:0]     sample_data,
  output logic [SEL_W-1:0]  sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  // Park select: the mux outputs 0 here, and a scan never uses this value.
  localparam logic [SEL_W-1:0] SelPark = '1;

  typedef enum logic [1:0] {StIdle, StSetup, StOut} state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  ch_q;
  logic [DW-1:0]     data_q;
  logic              valid_q;
  logic              done_q;

  // first_* : lowest enabled channel in the incoming mask (scan start).
  // next_*  : lowest enabled channel in the captured mask above the current select.
  logic              first_hit;
  logic [SEL_W-1:0]  first_idx;
  logic              next_hit;
  logic [SEL_W-1:0]  next_idx;

  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    // Iterate from the top down, so the last match written is the lowest index.
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_hit = 1'b1;
        first_idx = SEL_W'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_hit = 1'b1;
        next_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      sel_q   <= SelPark;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort has no effect here, so start wins when both are asserted.
          if (start) begin
            mask_q <= ch_mask;
            if (first_hit) begin
              sel_q   <= first_idx;
              state_q <= StSetup;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (abort) begin
            state_q <= StIdle;
            sel_q   <= SelPark;
            valid_q <= 1'b0;
          end else begin
            // sel has been stable for one cycle, so the mux output has settled.
            data_q  <= mux_out_i;
            ch_q    <= sel_q;
            valid_q <= 1'b1;
            state_q <= StOut;
          end
        end
        StOut: begin
          if (abort) begin
            // abort takes priority over a handshake in the same cycle.
            state_q <= StIdle;
            sel_q   <= SelPark;
            valid_q <= 1'b0;
          end else if (valid_q && sample_ready) begin
            valid_q <= 1'b0;
            if (next_hit) begin
              sel_q   <= next_idx;
              state_q <= StSetup;
            end else begin
              sel_q   <= SelPark;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          sel_q   <= SelPark;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o        = sel_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl.
// A behavioural model of the 31:1 mux drives mux_out_i. The expected samples
// for each scan are taken from the set bits of the mask, in ascending order.
module tb_mux_scan_ctrl;

  localparam int NCH = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_ready = 1'b0;
  logic [30:0] ch_mask = '0;
  logic [4:0]  sel_o;
  logic [4:0]  sample_ch;
  logic [1:0]  mux_out_i;
  logic [1:0]  sample_data;
  logic        sample_valid;
  logic        busy;
  logic        done;

  logic [1:0]  inp [32];

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  // Mux model: channels 0..30 are the inputs; select 31 drives 0.
  assign mux_out_i = (sel_o == 5'd31) ? 2'b00 : inp[sel_o];

  mux_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .ch_mask      (ch_mask),
    .sel_o        (sel_o),
    .mux_out_i    (mux_out_i),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_sel"}, 32'(sel_o), 32'd31);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // Runs one full scan: starts it, drives a random ready, scoreboards the samples
  // against the set bits of the mask, and checks the done timing.
  // Must be called at a negedge while the DUT is idle.
  task automatic run_scan(input logic [30:0] mask, input int ready_pct,
                          output int nsamp, output int first_ch, output int last_ch);
    int   exp_q[$];
    int   last_hs = -1;
    int   done_cyc = -1;
    bit   sel_bad = 0, hold_bad = 0, order_bad = 0, timing_bad = 0, overlap = 0;
    bit   prev_pend = 0;
    logic [4:0] prev_ch = '0;
    logic [1:0] prev_d = '0;
    logic rdy;
    nsamp = 0;
    first_ch = -1;
    last_ch = -1;
    for (int i = 0; i < NCH; i++) if (mask[i]) exp_q.push_back(i);
    ch_mask = mask;
    start = 1'b1;
    sample_ready = 1'b0;
    tick();
    start = 1'b0;
    ch_mask = 31'($urandom);  // must be ignored mid-scan
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done && sample_valid) overlap = 1;
      if (busy && (sel_o == 5'd31 || !mask[sel_o])) sel_bad = 1;
      if (prev_pend && (!sample_valid || sample_ch !== prev_ch || sample_data !== prev_d))
        hold_bad = 1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      rdy = ($urandom_range(99) < 32'(ready_pct));
      if (sample_valid && rdy) begin
        if (exp_q.size() == 0 || int'(sample_ch) != exp_q[0] || sample_data !== inp[sample_ch])
          order_bad = 1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (ready_pct == 100 && cyc != 2 * nsamp + 1) timing_bad = 1;
        if (nsamp == 0) first_ch = int'(sample_ch);
        last_ch = int'(sample_ch);
        nsamp++;
        last_hs = cyc;
      end
      prev_pend = sample_valid && !rdy;
      prev_ch = sample_ch;
      prev_d = sample_data;
      sample_ready = rdy;
      tick();
    end
    chk("scan_done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("scan_done_latency", 32'(done_cyc), 32'(last_hs + 1));
    chk("scan_missing", 32'(exp_q.size()), 32'd0);
    chk("scan_order_data", 32'(order_bad), 32'd0);
    chk("scan_hold", 32'(hold_bad), 32'd0);
    chk("scan_sel_enabled", 32'(sel_bad), 32'd0);
    chk("scan_done_valid_overlap", 32'(overlap), 32'd0);
    chk("scan_throughput", 32'(timing_bad), 32'd0);
    chk("scan_end_sel", 32'(sel_o), 32'd31);
    chk("scan_end_busy", 32'(busy), 32'd0);
    sample_ready = 1'b0;
    tick();
    chk("scan_done_single", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [30:0] mask;
    int          pct;
    int          n;
    int          first;
    int          last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ns, fc, lc;
    logic [30:0] m;

    vecs[0] = '{31'h7fff_ffff, 100, 31, 0, 30};
    vecs[1] = '{31'h0000_0421, 100, 3, 0, 10};
    vecs[2] = '{31'h0000_0008, 100, 1, 3, 3};
    vecs[3] = '{31'h0000_0000, 100, 0, -1, -1};
    vecs[4] = '{31'h4000_0000, 50, 1, 30, 30};
    vecs[5] = '{31'h5555_5555, 60, 16, 0, 30};
    vecs[6] = '{31'h2aaa_aaaa, 100, 15, 1, 29};

    for (int i = 0; i < 32; i++) inp[i] = (i < NCH) ? 2'(i % 4) : 2'b00;

    // Asynchronous reset, applied away from any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_idle("reset", 1'b0);
    chk("reset_data", 32'(sample_data), 32'd0);
    chk("reset_ch", 32'(sample_ch), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed scans from the vector table.
    for (int k = 0; k < 7; k++) begin
      run_scan(vecs[k].mask, vecs[k].pct, ns, fc, lc);
      chk($sformatf("vec%0d_count", k), 32'(ns), 32'(vecs[k].n));
      chk($sformatf("vec%0d_first", k), 32'(fc), 32'(vecs[k].first));
      chk($sformatf("vec%0d_last", k), 32'(lc), 32'(vecs[k].last));
    end

    // Single channel with back-pressure: valid, channel and data held.
    ch_mask = 31'h8;
    start = 1'b1;
    sample_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("bp_sel", 32'(sel_o), 32'd3);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_valid_early", 32'(sample_valid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_valid_%0d", c), 32'(sample_valid), 32'd1);
      chk($sformatf("bp_ch_%0d", c), 32'(sample_ch), 32'd3);
      chk($sformatf("bp_data_%0d", c), 32'(sample_data), 32'd3);
    end
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk_idle("bp_end", 1'b1);
    tick();
    chk("bp_done_once", 32'(done), 32'd0);

    // Empty mask: done on the next cycle, never busy; a start during that
    // done cycle is accepted.
    ch_mask = '0;
    start = 1'b1;
    tick();
    chk_idle("empty", 1'b1);
    ch_mask = 31'h4;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_sel", 32'(sel_o), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_setup", 1'b0);

    // Abort after the second handshake of a full-mask scan.
    for (int i = 0; i < NCH; i++) inp[i] = 2'($urandom);
    ch_mask = '1;
    start = 1'b1;
    sample_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_hs1_ch", 32'(sample_ch), 32'd0);
    tick();
    tick();
    chk("abort_hs2_ch", 32'(sample_ch), 32'd1);
    chk("abort_hs2_valid", 32'(sample_valid), 32'd1);
    tick();
    chk("abort_setup_sel", 32'(sel_o), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_after2", 1'b0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);

    // Abort beats a handshake in the same cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_hs_valid", 32'(sample_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_vs_hs", 1'b0);

    // start together with abort while idle: start wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins_busy", 32'(busy), 32'd1);
    chk("start_wins_sel", 32'(sel_o), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample_ready = 1'b0;
    chk_idle("start_wins_abort", 1'b0);

    // After the abort a new scan starts again from channel 0.
    run_scan('1, 100, ns, fc, lc);
    chk("rescan_first", 32'(fc), 32'd0);
    chk("rescan_count", 32'(ns), 32'd31);

    // Reset asserted while a sample is waiting in OUT.
    ch_mask = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid_valid", 32'(sample_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst_mid", 1'b0);
    chk("rst_mid_data", 32'(sample_data), 32'd0);
    chk("rst_mid_ch", 32'(sample_ch), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_scan(31'h0000_0421, 100, ns, fc, lc);
    chk("post_rst_count", 32'(ns), 32'd3);

    // Random masks, random mux data and random back-pressure.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NCH; i++) inp[i] = 2'($urandom);
      m = 31'($urandom);
      if (r % 3 == 0) m = m & 31'($urandom) & 31'($urandom);
      run_scan(m, (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 70 : 30), ns, fc, lc);
      chk($sformatf("rand%0d_count", r), 32'(ns), 32'($countones(m)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
